// File: rtl/sr_latch_driver.sv
// Drives the set/reset inputs of an SR latch from a valid/ready command stream:
// non-overlapping registered pulse, dead time, then synchronized feedback check.
module sr_latch_driver #(
    parameter int PULSE_W = 2,
    parameter int DEAD_W  = 1,
    parameter int CHK_W   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic cmd,
    output logic cmd_ready,
    output logic s,
    output logic r,
    input  logic q_fb,
    input  logic qb_fb,
    output logic done,
    output logic err,
    input  logic err_clr,
    output logic state_q
);

    localparam int MAX_P = (PULSE_W > DEAD_W) ? ((PULSE_W > CHK_W) ? PULSE_W : CHK_W)
                                              : ((DEAD_W > CHK_W) ? DEAD_W : CHK_W);
    localparam int CW = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_W - 1);
    localparam logic [CW-1:0] CHK_LAST   = CW'(CHK_W - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, DEAD, CHECK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          cmd_l, cmd_l_n;
    logic          s_n, r_n, done_n, err_n, state_q_n;
    logic          q_meta, q_sync, qb_meta, qb_sync;
    logic          match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_meta  <= 1'b0;
            q_sync  <= 1'b0;
            qb_meta <= 1'b0;
            qb_sync <= 1'b0;
        end else begin
            q_meta  <= q_fb;
            q_sync  <= q_meta;
            qb_meta <= qb_fb;
            qb_sync <= qb_meta;
        end
    end

    assign match     = (q_sync == cmd_l) && (qb_sync == ~cmd_l);
    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cmd_l   <= 1'b0;
            s       <= 1'b0;
            r       <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            state_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            cmd_l   <= cmd_l_n;
            s       <= s_n;
            r       <= r_n;
            done    <= done_n;
            err     <= err_n;
            state_q <= state_q_n;
        end
    end

    // s_n/r_n are only ever complementary (accept) or both low, so s&r can never be driven.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cmd_l_n   = cmd_l;
        s_n       = s;
        r_n       = r;
        done_n    = 1'b0;
        err_n     = err & ~err_clr;
        state_q_n = state_q;
        case (state)
            IDLE: begin
                s_n = 1'b0;
                r_n = 1'b0;
                if (cmd_valid) begin
                    cmd_l_n   = cmd;
                    state_q_n = cmd;
                    s_n       = cmd;
                    r_n       = ~cmd;
                    cnt_n     = '0;
                    state_n   = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == PULSE_LAST) begin
                    s_n     = 1'b0;
                    r_n     = 1'b0;
                    cnt_n   = '0;
                    state_n = DEAD;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DEAD: begin
                if (cnt == DEAD_LAST) begin
                    cnt_n   = '0;
                    state_n = CHECK;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            CHECK: begin
                if (match) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (cnt == CHK_LAST) begin
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                s_n     = 1'b0;
                r_n     = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver: default instance plus (1,1,1) and (4,3,5)
// parameter sets, each with a behavioural SR latch whose outputs can be stuck.
module tb_sr_latch_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cmd_valid_v, cmd_v, err_clr_v, stuck;
    logic [2:0] cmd_ready_v, s_v, r_v, done_v, err_v, state_q_v, q_fb_v, qb_fb_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int PW = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        localparam int DW = (g == 0) ? 1 : (g == 1) ? 1 : 3;
        localparam int KW = (g == 0) ? 3 : (g == 1) ? 1 : 5;
        logic q = 1'b0;

        sr_latch_driver #(.PULSE_W(PW), .DEAD_W(DW), .CHK_W(KW)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .cmd_valid(cmd_valid_v[g]),
            .cmd      (cmd_v[g]),
            .cmd_ready(cmd_ready_v[g]),
            .s        (s_v[g]),
            .r        (r_v[g]),
            .q_fb     (q_fb_v[g]),
            .qb_fb    (qb_fb_v[g]),
            .done     (done_v[g]),
            .err      (err_v[g]),
            .err_clr  (err_clr_v[g]),
            .state_q  (state_q_v[g])
        );

        always @(s_v[g] or r_v[g]) begin
            if (s_v[g] && !r_v[g]) q = 1'b1;
            else if (r_v[g] && !s_v[g]) q = 1'b0;
        end

        assign q_fb_v[g]  = stuck[g] ? 1'b0 : q;
        assign qb_fb_v[g] = stuck[g] ? 1'b1 : ~q;
    end

    always @(negedge clk)
        assert ((s_v & r_v) == 3'b000) else $error("FAIL s_and_r_overlap s=%b r=%b", s_v, r_v);

    typedef struct {
        int   idx;
        logic cmd;
        logic exp_err;
        logic exp_q;
        int   exp_lat;
        int   exp_pw;
        logic b2b;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         failures = 0;
    logic [2:0] prev_sr, prev_done, active, saw_s, saw_r;
    int         lat[3];
    int         pw[3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor_step();
        exp_t e;
        if (!rst_n) begin
            prev_sr   = '0;
            prev_done = '0;
            active    = '0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            logic sr;
            sr = s_v[i] | r_v[i];
            if (sr && !prev_sr[i]) begin
                active[i] = 1'b1;
                lat[i]    = 0;
                pw[i]     = 0;
                saw_s[i]  = 1'b0;
                saw_r[i]  = 1'b0;
                if (sbq.size() > 0 && sbq[0].b2b) chk("b2b_accept_at_done_fall", int'(prev_done[i]), 1);
            end else if (active[i]) begin
                lat[i]++;
            end
            if (s_v[i]) begin pw[i]++; saw_s[i] = 1'b1; end
            if (r_v[i]) begin pw[i]++; saw_r[i] = 1'b1; end
            if (done_v[i]) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: dut %0d raised done with no command pending", i);
                end else begin
                    e = sbq.pop_front();
                    chk("done_dut_index", i, e.idx);
                    chk("accept_to_done_latency", lat[i], e.exp_lat);
                    chk("pulse_width", pw[i], e.exp_pw);
                    chk("s_pulsed", int'(saw_s[i]), int'(e.cmd));
                    chk("r_pulsed", int'(saw_r[i]), int'(!e.cmd));
                    chk("err_at_done", int'(err_v[i]), int'(e.exp_err));
                    chk("state_q_at_done", int'(state_q_v[i]), int'(e.cmd));
                    chk("latch_q_at_done", int'(q_fb_v[i]), int'(e.exp_q));
                end
                active[i] = 1'b0;
            end
            prev_sr[i]   = sr;
            prev_done[i] = done_v[i];
        end
    endtask

    // Call at a negedge; holds cmd_valid until the accepting edge has passed.
    task automatic send(input int idx, input logic c, input logic exp_err, input logic exp_q,
                        input int exp_lat, input int exp_pw, input bit push);
        int n = 0;
        cmd_valid_v[idx] = 1'b1;
        cmd_v[idx]       = c;
        while (!cmd_ready_v[idx] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: dut %0d cmd_ready never rose", idx);
        end else if (push) begin
            sbq.push_back(exp_t'{idx, c, exp_err, exp_q, exp_lat, exp_pw, 1'b0});
        end
        @(negedge clk);
        cmd_valid_v[idx] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pending_commands_after_wait", sbq.size(), 0);
    endtask

    task automatic run_tests();
        logic c;
        int   pushed;
        int   n;
        rst_n = 1'b0;
        cmd_valid_v = '0; cmd_v = '0; err_clr_v = '0; stuck = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_cmd_ready", int'(cmd_ready_v[i]), 1);
            chk("reset_s_r", int'({s_v[i], r_v[i]}), 0);
            chk("reset_done_err_state", int'({done_v[i], err_v[i], state_q_v[i]}), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a set pulse
        send(0, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        chk("s_high_mid_drive", int'(s_v[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s_async_drop", int'(s_v[0]), 0);
        chk("r_async_low", int'(r_v[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", int'(cmd_ready_v[0]), 1);
        chk("post_reset_err", int'(err_v[0]), 0);
        chk("post_reset_state_q", int'(state_q_v[0]), 0);
        chk("post_reset_done", int'(done_v[0]), 0);

        // Set then reset with a responsive latch
        send(0, 1'b1, 1'b0, 1'b1, 4, 2, 1'b1);
        wait_idle();
        send(0, 1'b0, 1'b0, 1'b0, 4, 2, 1'b1);
        wait_idle();
        chk("qb_after_reset_cmd", int'(qb_fb_v[0]), 1);

        // Stuck latch: timeout, sticky err, err_clr, then set-wins-over-clear
        stuck[0] = 1'b1;
        send(0, 1'b1, 1'b1, 1'b0, 6, 2, 1'b1);
        wait_idle();
        chk("err_sticky", int'(err_v[0]), 1);
        err_clr_v[0] = 1'b1;
        @(negedge clk);
        chk("err_cleared", int'(err_v[0]), 0);
        send(0, 1'b1, 1'b1, 1'b0, 6, 2, 1'b1);
        wait_idle();
        @(negedge clk);
        chk("err_clr_held_after_set", int'(err_v[0]), 0);
        err_clr_v[0] = 1'b0;
        stuck[0] = 1'b0;
        @(negedge clk);

        // Busy handshake: valid held, cmd toggling; accepts only when ready, back-to-back at done fall
        pushed = 0;
        n = 0;
        c = 1'b0;
        cmd_valid_v[0] = 1'b1;
        while (pushed < 3 && n < 100) begin
            c = ~c;
            cmd_v[0] = c;
            if (cmd_ready_v[0]) begin
                sbq.push_back(exp_t'{0, c, 1'b0, c, 4, 2, (pushed > 0)});
                pushed++;
            end
            @(negedge clk);
            n++;
        end
        cmd_valid_v[0] = 1'b0;
        chk("busy_accept_count", pushed, 3);
        wait_idle();

        for (int k = 0; k < 1000; k++) begin
            c = 1'($urandom_range(0, 1));
            send(0, c, 1'b0, c, 4, 2, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        // Parameter sweep: (1,1,1) and (4,3,5), match and timeout
        send(1, 1'b1, 1'b0, 1'b1, 3, 1, 1'b1);
        wait_idle();
        stuck[1] = 1'b1;
        send(1, 1'b1, 1'b1, 1'b0, 3, 1, 1'b1);
        wait_idle();
        send(2, 1'b1, 1'b0, 1'b1, 8, 4, 1'b1);
        wait_idle();
        stuck[2] = 1'b1;
        send(2, 1'b1, 1'b1, 1'b0, 12, 4, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge clk);
                    monitor_step();
                end
            end
            run_tests();
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
